// File: rtl/count_ones_accumulator.sv
// count_ones_accumulator
//
// Streaming population-count accumulator. Counts the ones in each accepted
// WIDTH-bit beat, sums them across every beat of a frame (frames end at a
// beat carrying data_last), and presents one saturated total per frame on a
// valid/ready output.
//
// Ports:
//   clock          - single clock, all state updates on its rising edge
//   reset          - asynchronous, active-high reset
//   data           - input beat (WIDTH bits)
//   data_valid     - beat valid
//   data_last      - beat is the final beat of its frame (qualified by data_valid)
//   data_ready     - accumulator accepts a beat this cycle
//   total          - number of ones in the frame, saturated to all-ones
//   total_overflow - frame total exceeded 2^TOTAL_WIDTH-1
//   total_valid    - total/total_overflow are valid
//   total_ready    - downstream accepts the result
module count_ones_accumulator #(
  parameter int WIDTH            = 8,
  parameter int BEAT_COUNT_WIDTH = $clog2(WIDTH + 1),
  parameter int TOTAL_WIDTH      = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       data,
  input  logic                   data_valid,
  input  logic                   data_last,
  output logic                   data_ready,
  output logic [TOTAL_WIDTH-1:0] total,
  output logic                   total_overflow,
  output logic                   total_valid,
  input  logic                   total_ready
);

  typedef enum logic [0:0] {
    ST_ACCUMULATE = 1'b0,
    ST_OUTPUT     = 1'b1
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic [TOTAL_WIDTH-1:0]   acc_r;
  logic                     sticky_r;
  logic [TOTAL_WIDTH-1:0]   total_r;
  logic                     total_overflow_r;

  logic                     beat_accept_s;
  logic                     result_accept_s;
  logic [BEAT_COUNT_WIDTH-1:0] beat_count_s;
  logic [TOTAL_WIDTH:0]     sum_s;
  logic [TOTAL_WIDTH-1:0]   sat_sum_s;
  logic                     sum_over_s;

  // Number of set bits in one beat.
  function automatic logic [BEAT_COUNT_WIDTH-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [BEAT_COUNT_WIDTH-1:0] cnt;
    cnt = {BEAT_COUNT_WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + BEAT_COUNT_WIDTH'(v[i]);
    end
    return cnt;
  endfunction

  // Handshakes, per-beat count and the saturating sum.
  // The sum carries one extra bit so the carry-out flags overflow; since the
  // accumulator is already clamped and a beat adds at most WIDTH, that single
  // carry bit is enough to detect every overflow.
  always_comb begin
    beat_accept_s   = data_valid && (state_r == ST_ACCUMULATE);
    result_accept_s = total_ready && (state_r == ST_OUTPUT);
    beat_count_s    = popcount(data);
    sum_s           = {1'b0, acc_r} + (TOTAL_WIDTH + 1)'(beat_count_s);
    sum_over_s      = sum_s[TOTAL_WIDTH];
    if (sum_over_s) begin
      sat_sum_s = {TOTAL_WIDTH{1'b1}};
    end else begin
      sat_sum_s = sum_s[TOTAL_WIDTH-1:0];
    end
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_next_s = state_r;
    data_ready   = 1'b0;
    total_valid  = 1'b0;
    case (state_r)
      ST_ACCUMULATE: begin
        data_ready = 1'b1;
        if (beat_accept_s && data_last) begin
          state_next_s = ST_OUTPUT;
        end else begin
          state_next_s = ST_ACCUMULATE;
        end
      end
      ST_OUTPUT: begin
        total_valid = 1'b1;
        if (total_ready) begin
          state_next_s = ST_ACCUMULATE;
        end else begin
          state_next_s = ST_OUTPUT;
        end
      end
      default: begin
        state_next_s = ST_ACCUMULATE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_ACCUMULATE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Accumulator, sticky overflow and the held result registers.
  // A last beat moves the final sum straight into the result registers and
  // clears the accumulator, so the next frame starts from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_r            <= {TOTAL_WIDTH{1'b0}};
      sticky_r         <= 1'b0;
      total_r          <= {TOTAL_WIDTH{1'b0}};
      total_overflow_r <= 1'b0;
    end else if (beat_accept_s) begin
      if (data_last) begin
        total_r          <= sat_sum_s;
        total_overflow_r <= sticky_r | sum_over_s;
        acc_r            <= {TOTAL_WIDTH{1'b0}};
        sticky_r         <= 1'b0;
      end else begin
        acc_r            <= sat_sum_s;
        sticky_r         <= sticky_r | sum_over_s;
      end
    end
  end

  // result_accept_s only changes state; the held result is left as-is.
  assign total          = total_r;
  assign total_overflow = total_overflow_r;

endmodule

// File: tb/tb_count_ones_accumulator.sv
module tb_count_ones_accumulator;

  logic        clock = 1'b0;
  logic        reset;

  // Default-parameter instance (TOTAL_WIDTH = 16)
  logic [7:0]  data;
  logic        data_valid;
  logic        data_last;
  logic        data_ready;
  logic [15:0] total;
  logic        total_overflow;
  logic        total_valid;
  logic        total_ready;

  // Narrow-total instance (TOTAL_WIDTH = 4) for saturation
  logic [7:0]  data4;
  logic        data_valid4;
  logic        data_last4;
  logic        data_ready4;
  logic [3:0]  total4;
  logic        total_overflow4;
  logic        total_valid4;
  logic        total_ready4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  count_ones_accumulator dut (
    .clock(clock), .reset(reset),
    .data(data), .data_valid(data_valid), .data_last(data_last), .data_ready(data_ready),
    .total(total), .total_overflow(total_overflow), .total_valid(total_valid),
    .total_ready(total_ready)
  );

  count_ones_accumulator #(.TOTAL_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset),
    .data(data4), .data_valid(data_valid4), .data_last(data_last4), .data_ready(data_ready4),
    .total(total4), .total_overflow(total_overflow4), .total_valid(total_valid4),
    .total_ready(total_ready4)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [9:0] vpat;
  logic [9:0] lpat;

  initial begin
    reset = 1'b1;
    data = 8'h00; data_valid = 1'b0; data_last = 1'b0; total_ready = 1'b0;
    data4 = 8'h00; data_valid4 = 1'b0; data_last4 = 1'b0; total_ready4 = 1'b1;
    step();
    step();

    // Reset state
    check("rst_data_ready", 32'(data_ready), 32'd1);
    check("rst_total_valid", 32'(total_valid), 32'd0);
    check("rst_total", 32'(total), 32'd0);
    check("rst_overflow", 32'(total_overflow), 32'd0);
    reset = 1'b0;
    step();

    // Single-beat frame 8'hFF
    total_ready = 1'b1;
    data = 8'hFF; data_valid = 1'b1; data_last = 1'b1;
    step();
    data_valid = 1'b0; data_last = 1'b0; data = 8'h00;
    check("single_valid", 32'(total_valid), 32'd1);
    check("single_total", 32'(total), 32'd8);
    check("single_ovf", 32'(total_overflow), 32'd0);
    check("single_bubble", 32'(data_ready), 32'd0);
    step();
    check("single_valid_1cyc", 32'(total_valid), 32'd0);
    check("single_ready_back", 32'(data_ready), 32'd1);

    // Back-to-back frame 01,03,07,F0 -> 10, then backpressure
    data_valid = 1'b1;
    data = 8'h01; step();
    data = 8'h03; step();
    data = 8'h07; step();
    check("mid_frame_ready", 32'(data_ready), 32'd1);
    check("mid_frame_valid", 32'(total_valid), 32'd0);
    total_ready = 1'b0;
    data = 8'hF0; data_last = 1'b1; step();
    check("frame10_total", 32'(total), 32'd10);
    check("frame10_valid", 32'(total_valid), 32'd1);
    // Offer next frame's single zero beat while result is held
    data = 8'h00; data_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", 32'(total_valid), 32'd1);
      check("bp_total", 32'(total), 32'd10);
      check("bp_data_ready", 32'(data_ready), 32'd0);
    end
    total_ready = 1'b1;
    step();
    check("bp_release_valid", 32'(total_valid), 32'd0);
    check("bp_release_ready", 32'(data_ready), 32'd1);
    step();
    check("zero_frame_valid", 32'(total_valid), 32'd1);
    check("zero_frame_total", 32'(total), 32'd0);
    check("zero_frame_ovf", 32'(total_overflow), 32'd0);
    data_valid = 1'b0; data_last = 1'b0;
    step();
    check("zero_frame_done", 32'(total_valid), 32'd0);

    // Gapped frame: six 8'hAA beats, garbage 8'hFF when not valid
    vpat = 10'b11_0100_1101;  // bit k = data_valid in step k
    lpat = 10'b10_0000_0000;
    for (int k = 0; k < 10; k++) begin
      data_valid = vpat[k];
      data       = vpat[k] ? 8'hAA : 8'hFF;
      data_last  = vpat[k] ? lpat[k] : 1'b1;
      step();
    end
    data_valid = 1'b0; data_last = 1'b0;
    check("gapped_valid", 32'(total_valid), 32'd1);
    check("gapped_total", 32'(total), 32'd24);
    step();

    // Saturation on the 4-bit instance: 3 x FF = 24 -> F with overflow
    data_valid4 = 1'b1; data4 = 8'hFF; data_last4 = 1'b0;
    step(); step();
    data_last4 = 1'b1; step();
    data_valid4 = 1'b0; data_last4 = 1'b0;
    check("sat_valid", 32'(total_valid4), 32'd1);
    check("sat_total", 32'(total4), 32'hF);
    check("sat_ovf", 32'(total_overflow4), 32'd1);
    step();
    // Sticky must be cleared: 0F alone -> 4
    data_valid4 = 1'b1; data4 = 8'h0F; data_last4 = 1'b1;
    step();
    data_valid4 = 1'b0; data_last4 = 1'b0;
    check("post_sat_total", 32'(total4), 32'd4);
    check("post_sat_ovf", 32'(total_overflow4), 32'd0);
    step();
    // Exactly 15 (7F + FF) fits without overflow
    data_valid4 = 1'b1; data4 = 8'h7F; data_last4 = 1'b0;
    step();
    data4 = 8'hFF; data_last4 = 1'b1;
    step();
    data_valid4 = 1'b0; data_last4 = 1'b0;
    check("edge15_total", 32'(total4), 32'hF);
    check("edge15_ovf", 32'(total_overflow4), 32'd0);
    step();

    // Reset mid-frame: three FF beats then abort
    data_valid = 1'b1; data = 8'hFF; data_last = 1'b0;
    step(); step(); step();
    data_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_valid", 32'(total_valid), 32'd0);
    check("abort_ready", 32'(data_ready), 32'd1);
    step();
    reset = 1'b0;
    step();
    data_valid = 1'b1; data = 8'h01; data_last = 1'b1;
    step();
    data_valid = 1'b0; data_last = 1'b0;
    check("after_abort_total", 32'(total), 32'd1);
    check("after_abort_valid", 32'(total_valid), 32'd1);
    step();
    check("after_abort_done", 32'(total_valid), 32'd0);

    // Reset while a result is held: pending result discarded at once
    total_ready = 1'b0;
    data_valid = 1'b1; data = 8'h3C; data_last = 1'b1;
    step();
    data_valid = 1'b0; data_last = 1'b0;
    check("held_total", 32'(total), 32'd4);
    step();
    check("held_valid", 32'(total_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(total_valid), 32'd0);
    check("rst_out_total", 32'(total), 32'd0);
    check("rst_out_ready", 32'(data_ready), 32'd1);
    step();
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_ones_accumulator.md
# count_ones_accumulator

Streaming population-count accumulator. It consumes a valid/ready stream of WIDTH-bit beats grouped into frames by a `last` marker. It sums the number of high bits across all beats of a frame and emits one registered total per frame on a valid/ready output, with saturation and an overflow flag. It sits directly downstream of the combinational one-counting logic and turns per-vector counts into per-frame statistics.

## Interface
- `WIDTH`, 8, bit width of each input beat.
- `BEAT_COUNT_WIDTH`, `CLOG2(WIDTH+1)`, width of the per-beat popcount; must hold the value WIDTH.
- `TOTAL_WIDTH`, 16, width of the frame total; must be ≥ BEAT_COUNT_WIDTH.
- `clock`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `data`  input  WIDTH  input beat.
- `data_valid`  input  1  beat valid.
- `data_last`  input  1  beat is the final beat of its frame; qualified by `data_valid`.
- `data_ready`  output  1  accumulator accepts a beat this cycle.
- `total`  output  TOTAL_WIDTH  number of ones in the frame, saturated.
- `total_overflow`  output  1  frame total exceeded 2^TOTAL_WIDTH−1.
- `total_valid`  output  1  `total`/`total_overflow` valid.
- `total_ready`  input  1  downstream accepts the result.

## Operation
- Beat accepted when `data_valid && data_ready`. Result accepted when `total_valid && total_ready`.
- Per-beat popcount: combinational, BEAT_COUNT_WIDTH bits, range 0..WIDTH.
- Two states:
  - ACCUMULATE: `data_ready`=1, `total_valid`=0.
  - OUTPUT: `data_ready`=0, `total_valid`=1.
- ACCUMULATE behaviour:
  - Accepted beat with `data_last`=0: accumulator ← sat(accumulator + popcount). Stay in ACCUMULATE.
  - Accepted beat with `data_last`=1: output registers ← sat(accumulator + popcount), overflow ← sticky_overflow OR (sum > max). Accumulator and sticky overflow clear to 0. Go to OUTPUT.
- OUTPUT behaviour:
  - Result accepted → ACCUMULATE.
  - Otherwise hold. `total` and `total_overflow` must remain stable while `total_valid`=1 and `total_ready`=0.
- Saturation:
  - Sum computed at TOTAL_WIDTH+1 bits.
  - If the sum exceeds 2^TOTAL_WIDTH−1, the stored value clamps to all-ones and the sticky overflow is set.
  - Accumulator never wraps.
- Single-beat frame (first beat has `data_last`=1): result equals that beat's popcount.
- All-zero beats contribute 0. A frame of all-zero beats yields `total`=0, `total_overflow`=0.
- `data` and `data_last` are ignored when `data_valid`=0. `data_valid` while in OUTPUT is not accepted; upstream must hold the beat.
- No output change without an accepted input or accepted result.

## Timing
- Reset values:
  - State = ACCUMULATE.
  - Accumulator and sticky overflow = 0.
  - `total`=0, `total_overflow`=0, `total_valid`=0.
  - `data_ready`=1.
- Reset asserted mid-frame or mid-OUTPUT: partial frame and pending result are discarded immediately (asynchronous); no result is emitted for them.
- Latency: the last beat is accepted at edge N; `total_valid`=1 from edge N for the cycle after, i.e. visible the cycle following the last-beat handshake.
- Throughput:
  - One beat per cycle within a frame.
  - One bubble per frame: `data_ready`=0 for at least one cycle after each last beat, until the result is accepted.
  - If `total_ready`=1 when `total_valid` rises, `data_ready` returns to 1 the following cycle.
- `data_ready` and `total_valid` are decoded from registered state only; there is no combinational path from any input to any output.

## Test plan
- Reset, then one beat `data`=8'hFF with `last`=1 and `total_ready`=1 → `total`=8, `total_overflow`=0, valid for exactly 1 cycle one cycle after the handshake; `data_ready` low 1 cycle.
- Frame 8'h01, 8'h03, 8'h07, 8'hF0 (last), back-to-back → `total`=10; then frame 8'h00 (last) → `total`=0.
- Backpressure: `total_ready`=0 for 5 cycles after result 10 → `total_valid` held high, `total`=10 stable, `data_ready`=0, offered beat not consumed; on `total_ready`=1 the held beat is accepted the next cycle.
- Saturation with `TOTAL_WIDTH`=4: frame of three 8'hFF beats (sum 24) → `total`=4'hF, `total_overflow`=1. Next frame 8'h0F (last) → `total`=4, `total_overflow`=0 (sticky cleared).
- `data_valid` toggled randomly mid-frame with 8'hAA beats ×6 → `total`=24; beats where `data_valid`=0 carry 8'hFF garbage and must not count.
- Assert `reset` after 3 beats of 8'hFF, then send frame 8'h01 (last) → `total`=1; no result emitted for the aborted frame.
